ltc2333_read: RTL and testbench

Deserializer for the LTC2333 serial result stream; the read-side counterpart to the block that drives `cnv`/`scki`/`sdi`. It oversamples the ADC's echoed clock `scko` and data `sdo` in the fabric clock domain and assembles 24-bit result words (18-bit result, 3-bit channel ID, 3-bit SoftSpan). Completed words pass through a small FIFO and leave on an AXI-Stream master. A frame is opened by a `frame_start` pulse from the write side and holds `n_words` words.

---
 rtl/ltc2333_read_if.sv | 18 +
 rtl/ltc2333_read.sv | 207 ++++++++++++++++++++
 tb/tb_ltc2333_read.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ltc2333_read_if.sv
// rtl/ltc2333_read_if.sv - AXI-Stream result channel between ltc2333_read and its consumer
//
// Signals:
//   tdata  [31:0] : {5'b0, word_idx[2:0], raw[23:0]}
//   tvalid        : word available
//   tready        : consumer accepts
//   tlast         : last word of a frame
// Modports: master (producer side), slave (consumer side).

interface ltc2333_read_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ltc2333_read.sv
// rtl/ltc2333_read.sv - LTC2333 serial result deserializer with output FIFO
//
// Oversamples the echoed scko/sdo pins, assembles N_BITS-bit result words MSB
// first and hands them out through a first-word fall-through FIFO on an
// AXI-Stream master.
//
// Optional feature macro: LTC2333_READ_TLAST_EN
//   defined     : FIFO carries a last flag, m_axis.tlast marks the frame's final word
//   not defined : m_axis.tlast is tied to 0 and the FIFO is one bit narrower
//
// Ports:
//   clk, reset       : fabric clock (>= 4x scko), asynchronous active-high reset
//   frame_start      : one-cycle pulse opening a frame of n_words words (0..8)
//   scko, sdo        : asynchronous serial clock / data from the ADC
//   m_axis           : AXI-Stream master (tdata/tvalid/tready/tlast)
//   frame_done       : one-cycle pulse when a frame completes normally
//   busy_rd          : high while a frame is in progress
//   overflow         : sticky, a word was dropped on a full FIFO
//   timeout          : sticky, a frame aborted for lack of scko edges
//   clear_flags      : synchronous clear of overflow and timeout

module ltc2333_read #(
    parameter int N_BITS         = 24,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [3:0]           n_words,
    input  logic                 scko,
    input  logic                 sdo,
    ltc2333_read_if.master       m_axis,
    output logic                 frame_done,
    output logic                 busy_rd,
    output logic                 overflow,
    output logic                 timeout,
    input  logic                 clear_flags
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(N_BITS + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(N_BITS - 1);
    localparam logic [TCW-1:0] TO_LIMIT  = TCW'(TIMEOUT_CYCLES - 1);
`ifdef LTC2333_READ_TLAST_EN
    localparam int W = 28;
`else
    localparam int W = 27;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

    state_t          state;
    logic            scko_s1, scko_s2, scko_s3;
    logic            sdo_s1, sdo_s2;
    logic [23:0]     sh;
    logic [BCW-1:0]  bit_cnt;
    logic [TCW-1:0]  to_cnt;
    logic [2:0]      word_idx;
    logic [3:0]      n_lat;

    logic [W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;

    logic            edge_det, push, pop, full, do_write, is_last;
    logic [W-1:0]    entry;

    // Two-flop synchronizers; scko gets a third stage for rising-edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scko_s1 <= 1'b0;
            scko_s2 <= 1'b0;
            scko_s3 <= 1'b0;
            sdo_s1  <= 1'b0;
            sdo_s2  <= 1'b0;
        end else begin
            scko_s1 <= scko;
            scko_s2 <= scko_s1;
            scko_s3 <= scko_s2;
            sdo_s1  <= sdo;
            sdo_s2  <= sdo_s1;
        end
    end

    assign edge_det = scko_s2 & ~scko_s3;
    assign push     = (state == PUSH);
    assign full     = (count == FULL_CNT);
    assign pop      = m_axis.tvalid & m_axis.tready;
    // At full a simultaneous pop frees the slot being written.
    assign do_write = push & (~full | pop);
    assign is_last  = ({1'b0, word_idx} == (n_lat - 4'd1));

`ifdef LTC2333_READ_TLAST_EN
    assign entry        = {is_last, word_idx, sh};
    assign m_axis.tlast = m_axis.tvalid & mem[rd_ptr][27];
`else
    assign entry        = {word_idx, sh};
    assign m_axis.tlast = 1'b0;
`endif

    assign m_axis.tvalid = (count != '0);
    // Gated so the unreset storage never shows on the bus.
    assign m_axis.tdata  = m_axis.tvalid ? {5'b0, mem[rd_ptr][26:0]} : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !pop) begin
                count <= count + 1'b1;
            end else if (!do_write && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sh         <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            word_idx   <= '0;
            n_lat      <= '0;
            frame_done <= 1'b0;
            busy_rd    <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Cleared first so a flag set later in this cycle takes priority.
            if (clear_flags) begin
                overflow <= 1'b0;
                timeout  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        if (n_words == 4'd0) begin
                            frame_done <= 1'b1;
                        end else begin
                            n_lat    <= n_words;
                            word_idx <= '0;
                            bit_cnt  <= '0;
                            to_cnt   <= '0;
                            busy_rd  <= 1'b1;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (edge_det) begin
                        sh      <= {sh[22:0], sdo_s2};
                        bit_cnt <= bit_cnt + 1'b1;
                        to_cnt  <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state <= PUSH;
                        end
                    end else if (to_cnt == TO_LIMIT) begin
                        timeout <= 1'b1;
                        busy_rd <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                PUSH: begin
                    if (full && !pop) begin
                        overflow <= 1'b1;
                    end
                    word_idx <= word_idx + 1'b1;
                    bit_cnt  <= '0;
                    to_cnt   <= '0;
                    if (is_last) begin
                        frame_done <= 1'b1;
                        busy_rd    <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                default: begin
                    busy_rd <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ltc2333_read.sv
// tb/tb_ltc2333_read.sv - scoreboard testbench for ltc2333_read

module tb_ltc2333_read;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [3:0] n_words;
    logic       scko, sdo;
    logic       frame_done, busy_rd, overflow, timeout;
    logic       clear_flags;

    ltc2333_read_if m_axis ();

    ltc2333_read #(
        .N_BITS(24), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .n_words(n_words),
        .scko(scko), .sdo(sdo), .m_axis(m_axis), .frame_done(frame_done),
        .busy_rd(busy_rd), .overflow(overflow), .timeout(timeout),
        .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fd_cnt = 0;
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic l);
`ifdef LTC2333_READ_TLAST_EN
        exp_q.push_back({l, d});
`else
        exp_q.push_back({1'b0 & l, d});
`endif
    endtask

    // Monitor: every accepted beat is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && m_axis.tvalid && m_axis.tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected actual=%h required=none", m_axis.tdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({m_axis.tlast, m_axis.tdata} === e) passes++;
                else $display("FAIL beat actual=%h/%b required=%h/%b",
                              m_axis.tdata, m_axis.tlast, e[31:0], e[32]);
            end
        end
        if (!reset && frame_done) fd_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [3:0] n);
        @(negedge clk);
        frame_start = 1'b1;
        n_words = n;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Sends the top nb bits of d MSB first; scko low 3 and high 3 clk cycles per bit.
    task automatic send_bits(input logic [23:0] d, input int nb);
        for (int i = 23; i > 23 - nb; i--) begin
            sdo  = d[i];
            scko = 1'b0;
            idle(3);
            scko = 1'b1;
            idle(3);
        end
    endtask

    logic [23:0] ovf_words [8];
    int fd0;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0; n_words = 4'd0; scko = 1'b0; sdo = 1'b0;
        clear_flags = 1'b0; m_axis.tready = 1'b1;
        for (int i = 0; i < 8; i++) ovf_words[i] = 24'(16 * (i + 1));
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        chk("rst_tdata", m_axis.tdata, 32'd0);
        chk("rst_busy", {31'd0, busy_rd}, 32'd0);
        chk("rst_flags", {30'd0, overflow, timeout}, 32'd0);
        chk("rst_done", {31'd0, frame_done}, 32'd0);

        // Single word, frame_done 2 cycles after the detected last edge.
        expect_beat(32'h00A5A5A5, 1'b1);
        fd0 = fd_cnt;
        pulse_start(4'd1);
        chk("t1_busy", {31'd0, busy_rd}, 32'd1);
        send_bits(24'hA5A5A5, 24);
        idle(1);
        chk("t1_done_pulse", {31'd0, frame_done}, 32'd1);
        chk("t1_busy_fall", {31'd0, busy_rd}, 32'd0);
        idle(4);
        chk("t1_fd_count", fd_cnt - fd0, 1);

        // Three words with word_idx in tdata[26:24].
        expect_beat(32'h00000001, 1'b0);
        expect_beat(32'h01800000, 1'b0);
        expect_beat(32'h02FFFFFF, 1'b1);
        pulse_start(4'd3);
        send_bits(24'h000001, 24);
        send_bits(24'h800000, 24);
        send_bits(24'hFFFFFF, 24);
        idle(6);
        chk("t2_drained", exp_q.size(), 0);

        // Overflow: 8 words into a 4-entry FIFO with tready low.
        m_axis.tready = 1'b0;
        expect_beat(32'h00000010, 1'b0);
        expect_beat(32'h01000020, 1'b0);
        expect_beat(32'h02000030, 1'b0);
        expect_beat(32'h03000040, 1'b0);
        pulse_start(4'd8);
        for (int w = 0; w < 8; w++) send_bits(ovf_words[w], 24);
        idle(4);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        chk("t3_held_valid", {31'd0, m_axis.tvalid}, 32'd1);
        chk("t3_held_data", m_axis.tdata, 32'h00000010);
        m_axis.tready = 1'b1;
        idle(8);
        chk("t3_drained", exp_q.size(), 0);
        clear_flags = 1'b1;
        idle(1);
        clear_flags = 1'b0;
        chk("t3_overflow_clr", {31'd0, overflow}, 32'd0);

        // Timeout after 10 bits: no beat, no frame_done.
        fd0 = fd_cnt;
        pulse_start(4'd1);
        send_bits(24'h3FF000, 10);
        scko = 1'b0;
        idle(80);
        chk("t4_timeout", {31'd0, timeout}, 32'd1);
        chk("t4_idle", {31'd0, busy_rd}, 32'd0);
        chk("t4_no_done", fd_cnt - fd0, 0);
        chk("t4_no_beat", {31'd0, m_axis.tvalid}, 32'd0);
        clear_flags = 1'b1;
        idle(1);
        clear_flags = 1'b0;
        chk("t4_timeout_clr", {31'd0, timeout}, 32'd0);

        // n_words = 0 completes at once.
        fd0 = fd_cnt;
        pulse_start(4'd0);
        chk("t5_zero_done", {31'd0, frame_done}, 32'd1);
        chk("t5_zero_busy", {31'd0, busy_rd}, 32'd0);
        idle(3);
        chk("t5_zero_nodata", {31'd0, m_axis.tvalid}, 32'd0);

        // frame_start during SHIFT is ignored.
        fd0 = fd_cnt;
        expect_beat(32'h00123456, 1'b0);
        expect_beat(32'h01654321, 1'b1);
        pulse_start(4'd2);
        send_bits(24'h123456, 24);
        pulse_start(4'd5);
        send_bits(24'h654321, 24);
        idle(6);
        chk("t6_fd_count", fd_cnt - fd0, 1);
        chk("t6_idle", {31'd0, busy_rd}, 32'd0);

        // Reset mid-frame, then a clean single-word frame.
        fd0 = fd_cnt;
        expect_beat(32'h000F0F0F, 1'b0);
        pulse_start(4'd2);
        send_bits(24'h0F0F0F, 24);
        send_bits(24'hABCDEF, 12);
        m_axis.tready = 1'b0;
        idle(1);
        reset = 1'b1;
        scko = 1'b0;
        #1;
        chk("t7_rst_tvalid", {31'd0, m_axis.tvalid}, 32'd0);
        chk("t7_rst_busy", {31'd0, busy_rd}, 32'd0);
        idle(2);
        reset = 1'b0;
        m_axis.tready = 1'b1;
        idle(1);
        chk("t7_no_done", fd_cnt - fd0, 0);
        expect_beat(32'h00C3C3C3, 1'b1);
        pulse_start(4'd1);
        send_bits(24'hC3C3C3, 24);
        idle(6);
        chk("t7_fd_count", fd_cnt - fd0, 1);

        idle(4);
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
